// File: rtl/module_keypad_encoder.sv
// module_keypad_encoder
// Receive side of a 4x4 matrix keypad scan. The rows are synchronized and
// debounced, and row plus column are encoded into a 4-bit key code. The column
// scan is frozen while a key is being resolved. Each accepted key is offered to
// the consumer over a valid/ready handshake.
// Optional feature macro: KEYPAD_OVERRUN_EN adds an 'overrun' pulse output that
// flags a new key discarded because the previous one was still pending.
module module_keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 27000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] col_idx,
  input  logic [3:0] row_n,
  input  logic       key_ready,
  output logic       scan_hold,
  output logic       key_valid,
  output logic [3:0] key_code
`ifdef KEYPAD_OVERRUN_EN
  ,
  output logic       overrun
`endif
);

  localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  // Returns {single_key, row_index}; single_key is set only when exactly one
  // row line is low. Multi-key and no-key patterns both report no single key.
  function automatic logic [2:0] f_row_encode(input logic [3:0] rows);
    logic [2:0] enc;
    enc = 3'b000;
    case (rows)
      4'b1110: enc = 3'b100;
      4'b1101: enc = 3'b101;
      4'b1011: enc = 3'b110;
      4'b0111: enc = 3'b111;
      default: enc = 3'b000;
    endcase
    return enc;
  endfunction

  logic [3:0]    r_row_p0;
  logic [3:0]    r_row_p1;
  logic [1:0]    r_col_p0;
  logic [1:0]    r_col_p1;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_cap_row;
  logic [1:0]    r_cap_idx;
  logic [1:0]    r_cap_col;

  logic [2:0]    w_enc;
  logic          w_single;
  logic [1:0]    w_row_idx;
  logic          w_all_high;
  logic          w_match;
  logic          w_accept;

  // Stage p0 -> p1: synchronized rows and the column that produced them
  assign w_enc      = f_row_encode(r_row_p1);
  assign w_single   = w_enc[2];
  assign w_row_idx  = w_enc[1:0];
  assign w_all_high = &r_row_p1;
  assign w_match    = (r_row_p1 == r_cap_row);
  assign w_accept   = (r_state == S_DEBOUNCE) && w_match && (r_cnt == CNT_MAX);

  // Two-flop row synchronizer with a matching two-stage column delay pipe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row_p0 <= 4'hF;
      r_row_p1 <= 4'hF;
      r_col_p0 <= 2'd0;
      r_col_p1 <= 2'd0;
    end else begin
      r_row_p0 <= row_n;
      r_row_p1 <= r_row_p0;
      r_col_p0 <= col_idx;
      r_col_p1 <= r_col_p0;
    end
  end

  // Press/release debounce FSM with registered scan hold and key output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cap_row <= 4'hF;
      r_cap_idx <= 2'd0;
      r_cap_col <= 2'd0;
      scan_hold <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
`ifdef KEYPAD_OVERRUN_EN
      overrun   <= 1'b0;
`endif
    end else begin
`ifdef KEYPAD_OVERRUN_EN
      overrun <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            r_state   <= S_DEBOUNCE;
            r_cap_row <= r_row_p1;
            r_cap_idx <= w_row_idx;
            r_cap_col <= r_col_p1;
            r_cnt     <= '0;
            scan_hold <= 1'b1;
          end
        end
        S_DEBOUNCE: begin
          if (!w_match) begin
            r_state   <= S_IDLE;
            scan_hold <= 1'b0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= S_HELD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_HELD: begin
          if (w_all_high) begin
            r_state <= S_RELEASE;
            r_cnt   <= '0;
          end
        end
        S_RELEASE: begin
          if (!w_all_high) begin
            r_state <= S_HELD;
          end else if (r_cnt == CNT_MAX) begin
            r_state   <= S_IDLE;
            scan_hold <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          scan_hold <= 1'b0;
        end
      endcase

      // A same-edge handshake frees the slot, so the new key replaces the old
      if (w_accept) begin
        if (!key_valid || key_ready) begin
          key_code  <= {r_cap_idx, r_cap_col};
          key_valid <= 1'b1;
        end else begin
`ifdef KEYPAD_OVERRUN_EN
          overrun <= 1'b1;
`endif
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_module_keypad_encoder.sv
// Self-checking bench for module_keypad_encoder (DEBOUNCE_CYCLES = 4).
// The reference model works on run lengths of synchronized row samples rather
// than on explicit states: a key is accepted once DEBOUNCE_CYCLES+1 identical
// single-key samples arrive while armed, and re-arming needs DEBOUNCE_CYCLES+1
// all-high samples.
module tb_module_keypad_encoder;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] col_idx;
  logic [3:0] row_n;
  logic       key_ready;
  logic       scan_hold;
  logic       key_valid;
  logic [3:0] key_code;
`ifdef KEYPAD_OVERRUN_EN
  logic       overrun;
`endif

  always #5 clk = ~clk;

  module_keypad_encoder #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_idx   (col_idx),
    .row_n     (row_n),
    .key_ready (key_ready),
    .scan_hold (scan_hold),
    .key_valid (key_valid),
    .key_code  (key_code)
`ifdef KEYPAD_OVERRUN_EN
    ,
    .overrun   (overrun)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int rdy_mode;
  bit rst_rand;
  bit force_rst;
  int key_seen;
  int ovr_seen;
  logic [3:0] last_code;

  // reference model state
  logic [3:0] h_row [2];
  logic [1:0] h_col [2];
  bit         armed;
  int         run;
  int         hi_run;
  logic [3:0] run_pat;
  logic [1:0] run_col;
  bit         m_valid;
  logic [3:0] m_code;
  bit         m_hold;
  bit         m_ovr;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] row_index(input logic [3:0] s);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) if (!s[i]) idx = 2'(i);
    return idx;
  endfunction

  task automatic model_reset();
    h_row[0] = 4'hF; h_row[1] = 4'hF;
    h_col[0] = 2'd0; h_col[1] = 2'd0;
    armed = 1'b1; run = 0; hi_run = 0;
    run_pat = 4'hF; run_col = 2'd0;
    m_valid = 1'b0; m_code = 4'd0; m_hold = 1'b0; m_ovr = 1'b0;
  endtask

  // One clock edge of the reference model, using the inputs present at it
  task automatic model_edge();
    logic [3:0] s;
    logic [1:0] sc;
    bit single, accept;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s  = h_row[1];
    sc = h_col[1];
    h_row[1] = h_row[0]; h_col[1] = h_col[0];
    h_row[0] = row_n;    h_col[0] = col_idx;
    single = ($countones(~s) == 1);
    accept = 1'b0;
    m_ovr  = 1'b0;
    if (armed) begin
      if (single && run > 0 && s == run_pat) run++;
      else if (single) begin run = 1; run_pat = s; run_col = sc; end
      else run = 0;
      if (run == DC + 1) begin
        accept = 1'b1; armed = 1'b0; run = 0; hi_run = 0;
      end
    end else begin
      if (s == 4'hF) hi_run++; else hi_run = 0;
      if (hi_run == DC + 1) begin armed = 1'b1; hi_run = 0; end
    end
    m_hold = !armed || (run > 0);
    if (accept) begin
      if (!m_valid || key_ready) begin
        m_valid = 1'b1;
        m_code  = {row_index(run_pat), run_col};
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && key_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // Apply one cycle of stimulus, advance one edge, then check at the falling edge
  task automatic step(input logic [3:0] r, input logic [1:0] c);
    row_n   = r;
    col_idx = c;
    case (rdy_mode)
      0:       key_ready = 1'b0;
      1:       key_ready = 1'b1;
      default: key_ready = 1'($urandom_range(0, 1));
    endcase
    rst_n = !(force_rst || (rst_rand && $urandom_range(0, 149) == 0));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("scan_hold", 32'(scan_hold), 32'(m_hold));
    chk("key_valid", 32'(key_valid), 32'(m_valid));
    chk("key_code", 32'(key_code), 32'(m_code));
`ifdef KEYPAD_OVERRUN_EN
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (overrun === 1'b1) ovr_seen++;
`endif
    if (key_valid === 1'b1) begin
      key_seen++;
      last_code = key_code;
    end
  endtask

  function automatic logic [1:0] rcol();
    return 2'($urandom_range(0, 3));
  endfunction

  initial begin
    int k0;
    logic [3:0] pat, pat2;
    logic [1:0] c;
    int r, kind, steady;

    model_reset();
    rdy_mode = 1; rst_rand = 1'b0; force_rst = 1'b1;
    key_seen = 0; ovr_seen = 0; last_code = 4'd0;
    row_n = 4'hF; col_idx = 2'd0; key_ready = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    step(4'hF, 2'd0);
    step(4'hF, 2'd0);
    chk("rst_scan_hold", 32'(scan_hold), 32'd0);
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    chk("rst_key_code", 32'(key_code), 32'd0);
    force_rst = 1'b0;
    step(4'hF, 2'd0);

    // clean press: row 2, column 1
    for (int i = 1; i <= 10; i++) begin
      step(4'b1011, 2'd1);
      if (i == 2) chk("press_hold_e2", 32'(scan_hold), 32'd0);
      if (i == 3) chk("press_hold_e3", 32'(scan_hold), 32'd1);
      if (i == 6) chk("press_valid_e6", 32'(key_valid), 32'd0);
      if (i == 7) begin
        chk("press_valid_e7", 32'(key_valid), 32'd1);
        chk("press_code_e7", 32'(key_code), 32'b1001);
      end
      if (i == 8) chk("press_valid_e8", 32'(key_valid), 32'd0);
    end
    for (int i = 1; i <= 10; i++) begin
      step(4'hF, rcol());
      if (i == 6) chk("release_hold_e6", 32'(scan_hold), 32'd1);
      if (i == 7) chk("release_hold_e7", 32'(scan_hold), 32'd0);
    end

    // bounce on row 0, column 3
    k0 = key_seen;
    repeat (2) step(4'b1110, 2'd3);
    step(4'hF, 2'd3);
    repeat (10) step(4'b1110, 2'd3);
    repeat (10) step(4'hF, 2'd3);
    chk("bounce_keys", 32'(key_seen - k0), 32'd1);
    chk("bounce_code", 32'(last_code), 32'b0011);

    // backpressure: row 1, column 0
    rdy_mode = 0;
    repeat (12) step(4'b1101, 2'd0);
    repeat (10) step(4'hF, 2'd0);
    chk("bp_valid_held", 32'(key_valid), 32'd1);
    chk("bp_code_held", 32'(key_code), 32'b0100);
    rdy_mode = 1;
    step(4'hF, 2'd0);
    chk("bp_valid_clear", 32'(key_valid), 32'd0);

    // overrun: second key discarded while the first is pending
    rdy_mode = 0;
    k0 = ovr_seen;
    repeat (12) step(4'b1101, 2'd0);
    repeat (10) step(4'hF, 2'd0);
    repeat (12) step(4'b0111, 2'd2);
    chk("ovr_valid", 32'(key_valid), 32'd1);
    chk("ovr_code", 32'(key_code), 32'b0100);
`ifdef KEYPAD_OVERRUN_EN
    chk("ovr_pulses", 32'(ovr_seen - k0), 32'd1);
`endif
    repeat (10) step(4'hF, 2'd2);
    rdy_mode = 1;
    step(4'hF, 2'd0);

    // multi-key: rows 0 and 1 together
    k0 = key_seen;
    repeat (12) step(4'b1100, 2'd1);
    chk("multi_hold", 32'(scan_hold), 32'd0);
    repeat (3) step(4'hF, 2'd1);
    chk("multi_keys", 32'(key_seen - k0), 32'd0);

    // reset in the middle of debounce
    repeat (4) step(4'b1011, 2'd1);
    chk("mid_db_hold", 32'(scan_hold), 32'd1);
    force_rst = 1'b1;
    step(4'b1011, 2'd1);
    force_rst = 1'b0;
    chk("rst_db_hold", 32'(scan_hold), 32'd0);
    chk("rst_db_valid", 32'(key_valid), 32'd0);
    k0 = key_seen;
    repeat (8) step(4'hF, 2'd1);
    chk("rst_db_keys", 32'(key_seen - k0), 32'd0);

    // reset with a key pending
    rdy_mode = 0;
    repeat (12) step(4'b1110, 2'd2);
    repeat (10) step(4'hF, 2'd2);
    chk("pend_valid", 32'(key_valid), 32'd1);
    force_rst = 1'b1;
    step(4'hF, 2'd2);
    force_rst = 1'b0;
    chk("rst_pend_valid", 32'(key_valid), 32'd0);
    chk("rst_pend_code", 32'(key_code), 32'd0);
    rdy_mode = 1;
    k0 = key_seen;
    repeat (8) step(4'hF, 2'd2);
    chk("rst_pend_keys", 32'(key_seen - k0), 32'd0);

    // randomized episodes against the model
    rst_rand = 1'b1;
    for (int ep = 0; ep < 80; ep++) begin
      rdy_mode = int'($urandom_range(0, 2));
      kind     = int'($urandom_range(0, 5));
      r        = int'($urandom_range(0, 3));
      c        = rcol();
      pat      = 4'hF;
      pat[r]   = 1'b0;
      repeat ($urandom_range(1, 4)) step(4'hF, rcol());
      if (kind == 0) begin
        pat2 = pat;
        pat2[(r + 1) % 4] = 1'b0;
        repeat ($urandom_range(2, 8)) step(pat2, rcol());
      end else begin
        repeat ($urandom_range(0, 2)) begin
          repeat ($urandom_range(1, DC)) step(pat, c);
          repeat ($urandom_range(1, 3)) step(4'hF, c);
        end
        steady = int'($urandom_range(1, DC + 10));
        for (int i = 0; i < steady; i++) step(pat, (i < 3) ? c : rcol());
        repeat ($urandom_range(0, 2)) begin
          repeat ($urandom_range(1, DC + 1)) step(4'hF, rcol());
          repeat ($urandom_range(1, 3)) step(pat, rcol());
        end
      end
      repeat ($urandom_range(DC + 3, DC + 8)) step(4'hF, rcol());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
